// File: rtl/skinny_sbox_layer_ctrl.sv
// Skinny-64 masked S-box layer sequencer.
// Walks the 16 nibbles of a 4-share state through one shared, non-pipelined
// masked S-box. Each nibble gets its own fresh word, and each result is
// written back in place. Shares are never combined: every mux uses the same
// nibble index in every share.
// Optional build macro SBOX_TIMEOUT_EN adds a RUN-state watchdog, the
// TIMEOUT parameter and the sticky timeout_err output.

// Per-share nibble access: picks the active nibble and builds the written-back word
module skinny_sbox_share_lane #(
    parameter int NIBBLES = 16,
    parameter int CW      = 4
) (
    input  logic [4*NIBBLES-1:0] word,
    input  logic [CW-1:0]        idx,
    input  logic [3:0]           y,
    output logic [3:0]           x,
    output logic [4*NIBBLES-1:0] word_wb
);
    // Index one nibble and splice the S-box result into the same position
    always_comb begin
        x       = word[{idx, 2'b00} +: 4];
        word_wb = word;
        word_wb[{idx, 2'b00} +: 4] = y;
    end
endmodule

module skinny_sbox_layer_ctrl #(
    parameter int NIBBLES = 16,
    parameter int SHARES  = 4,
    parameter int RND_W   = 40
`ifdef SBOX_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [4*NIBBLES*SHARES-1:0] state_in,
    output logic                        busy,
    output logic                        done,
    output logic [4*NIBBLES*SHARES-1:0] state_out,
    output logic                        rnd_req,
    input  logic                        rnd_valid,
    input  logic [RND_W-1:0]            rnd_in,
    output logic [4*SHARES-1:0]         sbox_x,
    output logic [RND_W-1:0]            sbox_fresh,
    output logic                        sbox_restart,
    input  logic                        sbox_synch,
    input  logic [4*SHARES-1:0]         sbox_y
`ifdef SBOX_TIMEOUT_EN
    ,
    output logic                        timeout_err
`endif
);
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int SW = 4 * NIBBLES;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_RUN, S_NEXT, S_FIN} state_t;

    state_t                       state_q, state_d;
    logic [SHARES-1:0][SW-1:0]    st_q, st_d, st_wb;
    logic [SHARES-1:0][3:0]       x_q, x_d, lane_x, y_sh;
    logic [RND_W-1:0]             fresh_q, fresh_d;
    logic                         restart_q, restart_d;
    logic [CW-1:0]                cnt_q, cnt_d;

`ifdef SBOX_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q, wd_d;
    logic          err_q, err_d;
`endif

    assign y_sh = sbox_y;

    genvar k;
    generate
        for (k = 0; k < SHARES; k++) begin : g_lane
            skinny_sbox_share_lane #(.NIBBLES(NIBBLES), .CW(CW)) u_lane (
                .word    (st_q[k]),
                .idx     (cnt_q),
                .y       (y_sh[k]),
                .x       (lane_x[k]),
                .word_wb (st_wb[k])
            );
        end
    endgenerate

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            st_q      <= '0;
            x_q       <= '0;
            fresh_q   <= '0;
            restart_q <= 1'b0;
            cnt_q     <= '0;
`ifdef SBOX_TIMEOUT_EN
            wd_q      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            st_q      <= st_d;
            x_q       <= x_d;
            fresh_q   <= fresh_d;
            restart_q <= restart_d;
            cnt_q     <= cnt_d;
`ifdef SBOX_TIMEOUT_EN
            wd_q      <= wd_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state and datapath update; S-box operands only change on fetch acceptance
    always_comb begin
        state_d   = state_q;
        st_d      = st_q;
        x_d       = x_q;
        fresh_d   = fresh_q;
        restart_d = 1'b0;
        cnt_d     = cnt_q;
`ifdef SBOX_TIMEOUT_EN
        wd_d      = wd_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    st_d    = state_in;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (rnd_valid) begin
                    fresh_d   = rnd_in;
                    x_d       = lane_x;
                    restart_d = 1'b1;
                    state_d   = S_RUN;
`ifdef SBOX_TIMEOUT_EN
                    wd_d      = '0;
`endif
                end
            end
            S_RUN: begin
                // The restart cycle may still see Synch from the previous nibble
                if (!restart_q) begin
                    if (sbox_synch) begin
                        st_d    = st_wb;
                        state_d = S_NEXT;
                    end
`ifdef SBOX_TIMEOUT_EN
                    else if (wd_q == WW'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
`endif
                end
            end
            S_NEXT: begin
                if (cnt_q == CW'(NIBBLES - 1)) begin
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        busy    = (state_q == S_FETCH) || (state_q == S_RUN) || (state_q == S_NEXT);
        done    = (state_q == S_FIN);
        rnd_req = (state_q == S_FETCH);
    end

    assign state_out    = st_q;
    assign sbox_x       = x_q;
    assign sbox_fresh   = fresh_q;
    assign sbox_restart = restart_q;
`ifdef SBOX_TIMEOUT_EN
    assign timeout_err  = err_q;
`endif

endmodule

// File: tb/tb_skinny_sbox_layer_ctrl.sv
// Bench for skinny_sbox_layer_ctrl: behavioural 5-cycle masked S-box,
// random PRNG source with programmable stall, reference model of the layer.
// Build with SBOX_TIMEOUT_EN to also exercise the watchdog.
module tb_skinny_sbox_layer_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] state_in;
    logic         busy, done;
    logic [255:0] state_out;
    logic         rnd_req;
    logic         rnd_valid;
    logic [39:0]  rnd_in;
    logic [15:0]  sbox_x;
    logic [39:0]  sbox_fresh;
    logic         sbox_restart;
    logic         sbox_synch;
    logic [15:0]  sbox_y;
`ifdef SBOX_TIMEOUT_EN
    logic         timeout_err;
`endif

    int total = 0;
    int bad   = 0;

    skinny_sbox_layer_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .state_in     (state_in),
        .busy         (busy),
        .done         (done),
        .state_out    (state_out),
        .rnd_req      (rnd_req),
        .rnd_valid    (rnd_valid),
        .rnd_in       (rnd_in),
        .sbox_x       (sbox_x),
        .sbox_fresh   (sbox_fresh),
        .sbox_restart (sbox_restart),
        .sbox_synch   (sbox_synch),
        .sbox_y       (sbox_y)
`ifdef SBOX_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Skinny-64 4-bit S-box
    function automatic logic [3:0] sb(input logic [3:0] a);
        logic [63:0] t;
        t = 64'hF7E4D583B2A1096C;
        return t[{a, 2'b00} +: 4];
    endfunction

    function automatic logic [63:0] layer(input logic [63:0] v);
        logic [63:0] r;
        for (int n = 0; n < 16; n++) r[4*n +: 4] = sb(v[4*n +: 4]);
        return r;
    endfunction

    function automatic logic [63:0] unmask(input logic [255:0] s);
        return s[63:0] ^ s[127:64] ^ s[191:128] ^ s[255:192];
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // Behavioural S-box: result 5 cycles after the restart cycle.
    // Shares 1..3 of the output are taken from fresh bits; share 0 completes the sharing.
    bit sbox_en     = 1'b1;
    bit stray_synch = 1'b0;
    int lat = 0;
    always @(posedge clk) begin
        if (sbox_restart)             lat <= 1;
        else if (lat > 0 && lat < 5)  lat <= lat + 1;
        else                          lat <= 0;
    end
    always_comb begin
        sbox_y[7:4]   = sbox_fresh[7:4];
        sbox_y[11:8]  = sbox_fresh[11:8];
        sbox_y[15:12] = sbox_fresh[15:12];
        sbox_y[3:0]   = sb(sbox_x[3:0] ^ sbox_x[7:4] ^ sbox_x[11:8] ^ sbox_x[15:12])
                        ^ sbox_fresh[7:4] ^ sbox_fresh[11:8] ^ sbox_fresh[15:12];
        sbox_synch    = (sbox_en && lat == 5) || stray_synch;
    end

    // PRNG source: new word every cycle, optional stall on one nibble
    int fcount = 0;
    logic [39:0] flog [16];
    int stall_nib = -1, stall_len = 0, stall_done = 0;
    bit rnd_zero = 1'b0;
    logic [63:0] rw;
    always @(negedge clk) begin
        rw = {$urandom(), $urandom()};
        rnd_in = rnd_zero ? 40'd0 : rw[39:0];
        if (!busy) stall_done = 0;
        if (rnd_req && fcount == stall_nib && stall_done < stall_len) begin
            rnd_valid = 1'b0;
            stall_done++;
        end else begin
            rnd_valid = 1'b1;
        end
    end

    // Log every accepted fresh word, indexed by nibble
    always @(posedge clk) begin
        if (!rst)                         fcount <= 0;
        else if (start && !busy && !done) fcount <= 0;
        else if (rnd_req && rnd_valid) begin
            if (fcount < 16) flog[fcount] <= rnd_in;
            fcount <= fcount + 1;
        end
    end

    // Expected state after the layer, from the unmasked value and the logged fresh words
    function automatic logic [255:0] model(input logic [255:0] s);
        logic [63:0] u, m0, m1, m2, m3;
        logic [39:0] f;
        u = layer(unmask(s));
        for (int n = 0; n < 16; n++) begin
            f = flog[n];
            m1[4*n +: 4] = f[7:4];
            m2[4*n +: 4] = f[11:8];
            m3[4*n +: 4] = f[15:12];
            m0[4*n +: 4] = u[4*n +: 4] ^ f[7:4] ^ f[11:8] ^ f[15:12];
        end
        return {m3, m2, m1, m0};
    endfunction

    // Pulse start for one cycle; returns at the negedge of cycle 1 (start cycle is 0)
    task automatic do_start(input logic [255:0] s);
        @(negedge clk);
        state_in = s;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; k is the cycle index of done relative to the start cycle
    task automatic wait_done(input int k0, input int maxc, output int k, output bit got);
        k = k0;
        got = 1'b0;
        while (k < maxc && !got) begin
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b1; state_in = rand256();
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || rnd_req !== 1'b0 || sbox_restart !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl busy=%b done=%b rnd_req=%b restart=%b want all 0",
                     busy, done, rnd_req, sbox_restart);
        end
        total++;
        if (state_out !== 256'd0) begin
            bad++; $display("FAIL reset_state state_out=%h want 0", state_out);
        end
        total++;
        if (sbox_x !== 16'd0 || sbox_fresh !== 40'd0) begin
            bad++; $display("FAIL reset_sbox x=%h fresh=%h want 0", sbox_x, sbox_fresh);
        end
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_release busy=%b want 0", busy);
        end
    endtask

    task automatic test_zero_state();
        int k; bit got;
        rnd_zero = 1'b1;
        do_start(256'd0);
        total++;
        if (busy !== 1'b1 || rnd_req !== 1'b1) begin
            bad++; $display("FAIL first_cycle busy=%b rnd_req=%b want 1 1", busy, rnd_req);
        end
        wait_done(1, 400, k, got);
        // done lands in cycle 129: 130 cycles counting the start cycle
        total++;
        if (!got || k != 129) begin
            bad++; $display("FAIL zero_latency got=%0d cycle=%0d want done at 129", got, k);
        end
        total++;
        if (state_out[63:0] !== 64'hCCCCCCCCCCCCCCCC) begin
            bad++; $display("FAIL zero_share0 got=%h want cccccccccccccccc", state_out[63:0]);
        end
        total++;
        if (state_out[255:64] !== 192'd0) begin
            bad++; $display("FAIL zero_shares123 got=%h want 0", state_out[255:64]);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL done_busy busy=%b want 0", busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0) begin
            bad++; $display("FAIL done_width done=%b want 0 one cycle later", done);
        end
        rnd_zero = 1'b0;
    endtask

    task automatic test_nibble_order();
        logic [63:0] r1, r2, r3;
        logic [255:0] s;
        int k; bit got;
        r1 = {$urandom(), $urandom()};
        r2 = {$urandom(), $urandom()};
        r3 = {$urandom(), $urandom()};
        s = {r3, r2, r1, 64'h0123456789ABCDEF ^ r1 ^ r2 ^ r3};
        do_start(s);
        wait_done(1, 400, k, got);
        total++;
        if (!got || k != 129) begin
            bad++; $display("FAIL order_latency got=%0d cycle=%0d want 129", got, k);
        end
        total++;
        if (unmask(state_out) !== 64'hC6901A2B385D4E7F) begin
            bad++; $display("FAIL order_unmasked got=%h want c6901a2b385d4e7f", unmask(state_out));
        end
        total++;
        if (state_out !== model(s)) begin
            bad++; $display("FAIL order_shares got=%h want=%h", state_out, model(s));
        end
    endtask

    task automatic test_random();
        logic [255:0] s;
        int k; bit got;
        for (int i = 0; i < 4; i++) begin
            s = rand256();
            do_start(s);
            wait_done(1, 400, k, got);
            total++;
            if (!got || k != 129 || state_out !== model(s)) begin
                bad++;
                $display("FAIL random_%0d got=%0d cycle=%0d state=%h want=%h",
                         i, got, k, state_out, model(s));
            end
        end
    endtask

    task automatic test_stall();
        logic [255:0] s;
        logic [15:0] snap_x;
        logic [39:0] snap_f;
        int k, nst, herr; bit got;
        stall_nib = 5; stall_len = 7;
        s = rand256();
        do_start(s);
        k = 1; got = 1'b0; nst = 0; herr = 0;
        snap_x = '0; snap_f = '0;
        while (k < 400 && !got) begin
            if (rnd_req && fcount == 5) begin
                if (nst == 0) begin
                    snap_x = sbox_x; snap_f = sbox_fresh;
                end else if (sbox_x !== snap_x || sbox_fresh !== snap_f || sbox_restart !== 1'b0) begin
                    herr++;
                end
                nst++;
            end
            if (done) got = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        total++;
        if (herr != 0) begin
            bad++; $display("FAIL stall_hold changed_cycles=%0d want 0", herr);
        end
        total++;
        if (nst != 8) begin
            bad++; $display("FAIL stall_fetch_cycles got=%0d want 8", nst);
        end
        total++;
        if (!got || k != 136) begin
            bad++; $display("FAIL stall_latency got=%0d cycle=%0d want 136", got, k);
        end
        total++;
        if (state_out !== model(s)) begin
            bad++; $display("FAIL stall_result got=%h want=%h", state_out, model(s));
        end
        stall_nib = -1; stall_len = 0;
    endtask

    task automatic test_mid_reset();
        int n, dones;
        do_start(rand256());
        n = 0;
        while (fcount < 10 && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (fcount < 10) begin
            bad++; $display("FAIL midrst_reach fetched=%0d want 10", fcount);
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || rnd_req !== 1'b0 || state_out !== 256'd0 || sbox_x !== 16'd0) begin
            bad++;
            $display("FAIL midrst_idle busy=%b rnd_req=%b state=%h x=%h want idle zeros",
                     busy, rnd_req, state_out, sbox_x);
        end
        rst = 1'b1;
        dones = 0;
        repeat (150) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones != 0 || busy !== 1'b0) begin
            bad++; $display("FAIL midrst_nodone dones=%0d busy=%b want 0 0", dones, busy);
        end
    endtask

    task automatic test_busy_start();
        logic [255:0] s1, s2;
        int k; bit got;
        s1 = rand256(); s2 = rand256();
        do_start(s1);
        repeat (40) @(negedge clk);
        state_in = s2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("FAIL busy_start_busy busy=%b want 1", busy);
        end
        wait_done(42, 400, k, got);
        total++;
        if (!got || k != 129 || state_out !== model(s1)) begin
            bad++;
            $display("FAIL busy_start_ignored got=%0d cycle=%0d state=%h want=%h",
                     got, k, state_out, model(s1));
        end
    endtask

    task automatic test_idle_synch();
        logic [255:0] s, e;
        int k, errs; bit got;
        s = rand256();
        do_start(s);
        wait_done(1, 400, k, got);
        e = model(s);
        total++;
        if (!got || state_out !== e) begin
            bad++; $display("FAIL idle_pre got=%0d state=%h want=%h", got, state_out, e);
        end
        errs = 0;
        stray_synch = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (state_out !== e || busy !== 1'b0 || rnd_req !== 1'b0 || sbox_restart !== 1'b0) errs++;
        end
        stray_synch = 1'b0;
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL idle_synch disturbed_cycles=%0d want 0", errs);
        end
    endtask

`ifdef SBOX_TIMEOUT_EN
    task automatic test_timeout();
        int k, errs, dones;
        sbox_en = 1'b0;
        do_start(rand256());
        k = 1; errs = 0;
        if (timeout_err !== 1'b0 || busy !== 1'b1) errs++;
        while (k < 17) begin
            @(negedge clk);
            k++;
            if (timeout_err !== 1'b0 || busy !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL tmo_early bad_cycles=%0d want 0", errs);
        end
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL tmo_fire err=%b busy=%b want 1 0", timeout_err, busy);
        end
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        total++;
        if (dones != 0 || timeout_err !== 1'b1) begin
            bad++; $display("FAIL tmo_sticky dones=%0d err=%b want 0 1", dones, timeout_err);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (timeout_err !== 1'b0) begin
            bad++; $display("FAIL tmo_clear err=%b want 0", timeout_err);
        end
        sbox_en = 1'b1;
    endtask
`endif

    initial begin
        rst = 1'b0;
        start = 1'b0;
        state_in = '0;
        test_reset();
        test_zero_state();
        test_nibble_order();
        test_random();
        test_stall();
        test_mid_reset();
        test_busy_start();
        test_idle_synch();
`ifdef SBOX_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/skinny_sbox_layer_ctrl.md
Name: skinny_sbox_layer_ctrl

Overview:
Sequencer that applies the masked Skinny-64 S-box to all 16 nibbles of a 4-share state. It uses one shared instance of the 4-share, d=3 masked S-box (40 fresh bits per evaluation, clock-gated output register, Synch handshake). It loads the shared state, serially feeds one nibble at a time to the S-box, and fetches 40 fresh random bits per nibble from the PRNG. It writes each S-box result back in place and signals completion to the round datapath.

Parameters:
NIBBLES, 16, nibbles per state (state width = 4*NIBBLES per share)
SHARES, 4, number of shares (security order 3)
RND_W, 40, fresh bits consumed per S-box evaluation
TIMEOUT, 15, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begins a layer pass (ignored unless idle)
state_in  in  4*NIBBLES*SHARES  shared state; share k occupies bits [64k+63:64k]; sampled on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when all nibbles are processed
state_out  out  4*NIBBLES*SHARES  internal state register, same share layout as state_in
rnd_req  out  1  request for one RND_W-bit fresh word
rnd_valid  in  1  fresh word available
rnd_in  in  RND_W  fresh word
sbox_x  out  4*SHARES  current nibble, share k in bits [4k+3:4k]
sbox_fresh  out  RND_W  latched fresh word for the S-box
sbox_restart  out  1  one-cycle pulse restarting the S-box latency counter
sbox_synch  in  1  S-box result valid (the S-box's Synch output)
sbox_y  in  4*SHARES  S-box output shares
timeout_err  out  1  sticky error flag; present only with SBOX_TIMEOUT_EN

Behaviour:
- Reset (rst=0 at a clk edge) puts the block in IDLE. On reset: busy=0, done=0, rnd_req=0, sbox_restart=0, state_out=0, sbox_x=0, sbox_fresh=0, nibble counter=0, timeout_err=0.
- Reset mid-operation aborts the pass immediately: no done pulse and no partial writeback beyond what is already registered.
- FSM states:
  - IDLE: start=1 -> latch state_in, counter=0, busy=1, go to FETCH.
  - FETCH: rnd_req=1. When rnd_valid=1, latch rnd_in into sbox_fresh, latch nibble[counter] of every share into sbox_x, pulse sbox_restart next cycle, go to RUN. rnd_req drops in the cycle after acceptance.
  - RUN: sbox_x and sbox_fresh are held constant for the whole evaluation, because the S-box gadgets are non-pipelined. When sbox_synch=1, write sbox_y share k into nibble[counter] of share k, then go to NEXT.
  - NEXT: if counter=NIBBLES-1, go to FIN; otherwise counter+1 and go to FETCH.
  - FIN: done=1 for exactly one cycle, busy=0, return to IDLE.
- sbox_synch is ignored outside RUN, and in the RUN cycle that carries sbox_restart, so that a stale Synch from a previous evaluation is rejected.
- Nibble order: nibble 0 = bits [3:0] of each share, ascending to nibble 15.
- A start pulse while busy=1 is ignored. start and done in the same cycle cannot occur, since done is only asserted from FIN.
- Never recombine shares: every datapath mux selects the same nibble index in all shares, with no share-crossing logic.
- Latency per nibble = 1 (FETCH, rnd_valid already high) + 1 (restart) + S-box latency (5) + 1 (NEXT). Full pass with rnd_valid tied high is 16*8 + 2 = 130 cycles from start to done.
- state_out is stable and valid from the done cycle until the next accepted start.

Optional Feature:
SBOX_TIMEOUT_EN:
- Defined: a cycle counter runs in RUN. If sbox_synch is not seen within TIMEOUT cycles after sbox_restart, timeout_err is set (sticky until rst=0), the FSM goes to IDLE, busy drops, and no done pulse is issued.
- Not defined: RUN waits indefinitely, the timeout_err port is absent, and no watchdog logic is synthesized.

Test Plan:
- Reset check: hold rst=0 for 3 cycles with start=1 -> busy=0, done=0, rnd_req=0, state_out=0.
- Unshared zero state: state_in share0=0x0000000000000000, shares 1-3=0, rnd_valid=1 -> done after 130 cycles; share0 of state_out = 0xCCCCCCCCCCCCCCCC.
- Nibble order: share0=0x0123456789ABCDEF, random shares 1-3 XORed so the unmasked value is unchanged -> XOR of output shares = 0xC6901A2B385D4E7F.
- Randomness stall: rnd_valid low for 7 cycles on nibble 5 -> sbox_x and sbox_fresh stay stable, no sbox_restart, final result is unchanged, and the pass takes 7 extra cycles.
- Mid-pass reset and stray inputs: rst=0 during nibble 9 -> IDLE next cycle, no done. A second start while busy -> ignored. sbox_synch pulses in IDLE -> no state change.
- With SBOX_TIMEOUT_EN: sbox_synch tied 0 -> timeout_err=1 after 15 RUN cycles, busy=0, no done. timeout_err clears only on rst=0.
